// File: rtl/otter_pkg.sv
// Shared types and encodings for the OTTER program-counter sequencer.
package otter_pkg;

    typedef enum logic [1:0] {
        FETCH,
        EXEC,
        WB,
        INTR
    } pcs_state_t;

    // RV32I major opcodes the sequencer cares about
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // Branch funct3 encodings
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // SYSTEM funct3 used by mret (ecall/ebreak share it but are not sequenced here)
    localparam logic [2:0] F3_PRIV = 3'b000;

endpackage : otter_pkg

// File: rtl/otter_next_pc.sv
// Combinational branch resolution and next-PC selection for the EXEC state.
module otter_next_pc
    import otter_pkg::*;
(
    input  logic [6:0]  opcode_i,
    input  logic [2:0]  funct3_i,
    input  logic        br_eq_i,
    input  logic        br_lt_i,
    input  logic        br_ltu_i,
    input  logic [31:0] pc_plus4_i,
    input  logic [31:0] jal_tgt_i,
    input  logic [31:0] jalr_tgt_i,
    input  logic [31:0] branch_tgt_i,
    input  logic [31:0] mepc_i,
    output logic        br_taken_o,
    output logic [31:0] next_pc_o
);

    logic cond;

    // JALR clears bit 0 of its target, so that bit is never consumed
    logic unused_jalr_lsb;
    assign unused_jalr_lsb = jalr_tgt_i[0];

    // Branch condition from funct3; reserved codes 010/011 never take
    always_comb begin
        cond = 1'b0;
        unique case (funct3_i)
            F3_BEQ:  cond = br_eq_i;
            F3_BNE:  cond = !br_eq_i;
            F3_BLT:  cond = br_lt_i;
            F3_BGE:  cond = !br_lt_i;
            F3_BLTU: cond = br_ltu_i;
            F3_BGEU: cond = !br_ltu_i;
            default: cond = 1'b0;
        endcase
        br_taken_o = (opcode_i == OP_BRANCH) && cond;
    end

    // Next-PC mux; target alignment bits are passed through unchecked
    always_comb begin
        next_pc_o = pc_plus4_i;
        if (opcode_i == OP_JAL) begin
            next_pc_o = jal_tgt_i;
        end else if (opcode_i == OP_JALR) begin
            next_pc_o = {jalr_tgt_i[31:1], 1'b0};
        end else if (br_taken_o) begin
            next_pc_o = branch_tgt_i;
        end else if (opcode_i == OP_SYSTEM && funct3_i == F3_PRIV) begin
            next_pc_o = mepc_i;
        end
    end

endmodule : otter_next_pc

// File: rtl/pc_sequencer.sv
// Multi-cycle PC sequencer: FETCH/EXEC/WB/INTR FSM, PC register, retire counter.
module pc_sequencer
    import otter_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [6:0]  PCS_opcode,
    input  logic [2:0]  PCS_funct3,
    input  logic        PCS_br_eq,
    input  logic        PCS_br_lt,
    input  logic        PCS_br_ltu,
    input  logic [31:0] PCS_jal_tgt,
    input  logic [31:0] PCS_jalr_tgt,
    input  logic [31:0] PCS_branch_tgt,
    input  logic [31:0] PCS_mtvec,
    input  logic [31:0] PCS_mepc,
    input  logic        PCS_intr,
    input  logic        PCS_mem_ack,
    output logic [31:0] PCS_pc,
    output logic [31:0] PCS_pc_plus4,
    output logic        PCS_fetch_en,
    output logic        PCS_exec,
    output logic        PCS_wb,
    output logic        PCS_br_taken,
    output logic        PCS_int_taken,
    output logic [31:0] PCS_retired
);

    pcs_state_t  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] retired_q, retired_d;
    logic [31:0] next_pc;
    logic        br_taken_raw;

    assign PCS_pc       = pc_q;
    assign PCS_pc_plus4 = pc_q + 32'd4;
    assign PCS_retired  = retired_q;

    otter_next_pc u_next_pc (
        .opcode_i     (PCS_opcode),
        .funct3_i     (PCS_funct3),
        .br_eq_i      (PCS_br_eq),
        .br_lt_i      (PCS_br_lt),
        .br_ltu_i     (PCS_br_ltu),
        .pc_plus4_i   (PCS_pc_plus4),
        .jal_tgt_i    (PCS_jal_tgt),
        .jalr_tgt_i   (PCS_jalr_tgt),
        .branch_tgt_i (PCS_branch_tgt),
        .mepc_i       (PCS_mepc),
        .br_taken_o   (br_taken_raw),
        .next_pc_o    (next_pc)
    );

    // Moore state decodes; fetch enable is also gated by reset
    always_comb begin
        PCS_fetch_en  = (state_q == FETCH) && RST_N;
        PCS_exec      = (state_q == EXEC);
        PCS_wb        = (state_q == WB);
        PCS_int_taken = (state_q == INTR);
        PCS_br_taken  = (state_q == EXEC) && br_taken_raw;
    end

    // Next state, PC and retire count; PC is latched leaving EXEC for every opcode
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        retired_d = retired_q;
        unique case (state_q)
            FETCH: begin
                if (PCS_mem_ack) begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                pc_d = next_pc;
                if (PCS_opcode == OP_LOAD) begin
                    state_d = WB;
                end else begin
                    retired_d = retired_q + 32'd1;
                    state_d   = PCS_intr ? INTR : FETCH;
                end
            end
            WB: begin
                if (PCS_mem_ack) begin
                    retired_d = retired_q + 32'd1;
                    state_d   = PCS_intr ? INTR : FETCH;
                end
            end
            INTR: begin
                pc_d    = PCS_mtvec;
                state_d = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= FETCH;
            pc_q      <= RESET_VEC;
            retired_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            retired_q <= retired_d;
        end
    end

endmodule : pc_sequencer

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer.
module tb_pc_sequencer;

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;

    logic        CLK;
    logic        RST_N;
    logic [6:0]  PCS_opcode;
    logic [2:0]  PCS_funct3;
    logic        PCS_br_eq, PCS_br_lt, PCS_br_ltu;
    logic [31:0] PCS_jal_tgt, PCS_jalr_tgt, PCS_branch_tgt, PCS_mtvec, PCS_mepc;
    logic        PCS_intr, PCS_mem_ack;
    logic [31:0] PCS_pc, PCS_pc_plus4, PCS_retired;
    logic        PCS_fetch_en, PCS_exec, PCS_wb, PCS_br_taken, PCS_int_taken;

    int n_checks = 0;
    int n_fail   = 0;

    pc_sequencer #(.RESET_VEC(32'h0000_0100)) dut (
        .CLK            (CLK),
        .RST_N          (RST_N),
        .PCS_opcode     (PCS_opcode),
        .PCS_funct3     (PCS_funct3),
        .PCS_br_eq      (PCS_br_eq),
        .PCS_br_lt      (PCS_br_lt),
        .PCS_br_ltu     (PCS_br_ltu),
        .PCS_jal_tgt    (PCS_jal_tgt),
        .PCS_jalr_tgt   (PCS_jalr_tgt),
        .PCS_branch_tgt (PCS_branch_tgt),
        .PCS_mtvec      (PCS_mtvec),
        .PCS_mepc       (PCS_mepc),
        .PCS_intr       (PCS_intr),
        .PCS_mem_ack    (PCS_mem_ack),
        .PCS_pc         (PCS_pc),
        .PCS_pc_plus4   (PCS_pc_plus4),
        .PCS_fetch_en   (PCS_fetch_en),
        .PCS_exec       (PCS_exec),
        .PCS_wb         (PCS_wb),
        .PCS_br_taken   (PCS_br_taken),
        .PCS_int_taken  (PCS_int_taken),
        .PCS_retired    (PCS_retired)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Pulse reset for one cycle; returns at a falling edge with the DUT in FETCH
    task automatic do_reset();
        PCS_mem_ack = 1'b0;
        PCS_intr    = 1'b0;
        RST_N       = 1'b0;
        @(negedge CLK);
        RST_N = 1'b1;
    endtask

    // Called at a falling edge in FETCH; fetch acked at once, returns one cycle after EXEC
    task automatic do_instr(input logic [6:0] op, input logic [2:0] f3,
                            input logic [2:0] flags, input logic exp_br, input string tag);
        PCS_opcode  = op;
        PCS_funct3  = f3;
        {PCS_br_eq, PCS_br_lt, PCS_br_ltu} = flags;
        PCS_mem_ack = 1'b1;
        @(negedge CLK);
        check_val({tag, ".exec"}, 32'(PCS_exec), 32'd1);
        check_val({tag, ".br_taken"}, 32'(PCS_br_taken), 32'(exp_br));
        PCS_mem_ack = 1'b0;
        @(negedge CLK);
    endtask

    typedef struct {
        logic [2:0] f3;
        logic [2:0] flags;  // {eq, lt, ltu}
        logic       taken;
    } br_vec_t;

    br_vec_t tbl[14];

    initial begin
        tbl[0]  = '{3'b000, 3'b100, 1'b1};
        tbl[1]  = '{3'b000, 3'b011, 1'b0};
        tbl[2]  = '{3'b001, 3'b100, 1'b0};
        tbl[3]  = '{3'b001, 3'b011, 1'b1};
        tbl[4]  = '{3'b100, 3'b010, 1'b1};
        tbl[5]  = '{3'b100, 3'b101, 1'b0};
        tbl[6]  = '{3'b101, 3'b010, 1'b0};
        tbl[7]  = '{3'b101, 3'b101, 1'b1};
        tbl[8]  = '{3'b110, 3'b001, 1'b1};
        tbl[9]  = '{3'b110, 3'b110, 1'b0};
        tbl[10] = '{3'b111, 3'b001, 1'b0};
        tbl[11] = '{3'b111, 3'b110, 1'b1};
        tbl[12] = '{3'b010, 3'b111, 1'b0};
        tbl[13] = '{3'b011, 3'b111, 1'b0};

        PCS_opcode     = OP_IMM;
        PCS_funct3     = 3'b000;
        {PCS_br_eq, PCS_br_lt, PCS_br_ltu} = 3'b000;
        PCS_jal_tgt    = 32'h0000_0400;
        PCS_jalr_tgt   = 32'h0000_0303;
        PCS_branch_tgt = 32'h0000_0200;
        PCS_mtvec      = 32'h0000_01C0;
        PCS_mepc       = 32'h0000_0088;
        PCS_intr       = 1'b0;
        PCS_mem_ack    = 1'b1;
        RST_N          = 1'b0;

        // Reset values, with ack asserted to show the FSM is held
        repeat (2) @(negedge CLK);
        check_val("rst.pc", PCS_pc, 32'h100);
        check_val("rst.pc_plus4", PCS_pc_plus4, 32'h104);
        check_val("rst.retired", PCS_retired, 32'd0);
        check_val("rst.fetch_en", 32'(PCS_fetch_en), 32'd0);
        check_val("rst.exec", 32'(PCS_exec), 32'd0);
        RST_N       = 1'b1;
        PCS_mem_ack = 1'b0;
        #1;
        check_val("rel.fetch_en", 32'(PCS_fetch_en), 32'd1);
        @(negedge CLK);
        check_val("stall.fetch_en", 32'(PCS_fetch_en), 32'd1);
        check_val("stall.exec", 32'(PCS_exec), 32'd0);

        // Branch table from pc = 0x100
        foreach (tbl[i]) begin
            do_reset();
            do_instr(OP_BRANCH, tbl[i].f3, tbl[i].flags, tbl[i].taken, $sformatf("br%0d", i));
            check_val($sformatf("br%0d.pc", i), PCS_pc, tbl[i].taken ? 32'h200 : 32'h104);
            check_val($sformatf("br%0d.retired", i), PCS_retired, 32'd1);
        end

        // Non-branch opcode with beq-style fields must not branch
        do_reset();
        do_instr(OP_IMM, 3'b000, 3'b111, 1'b0, "nonbr");
        check_val("nonbr.pc", PCS_pc, 32'h104);

        // Jumps, mret and non-mret SYSTEM
        do_reset();
        do_instr(OP_JALR, 3'b000, 3'b000, 1'b0, "jalr");
        check_val("jalr.pc", PCS_pc, 32'h302);
        do_reset();
        do_instr(OP_JAL, 3'b000, 3'b000, 1'b0, "jal");
        check_val("jal.pc", PCS_pc, 32'h400);
        do_reset();
        do_instr(OP_SYSTEM, 3'b000, 3'b000, 1'b0, "mret");
        check_val("mret.pc", PCS_pc, 32'h88);
        do_reset();
        do_instr(OP_SYSTEM, 3'b001, 3'b000, 1'b0, "csr");
        check_val("csr.pc", PCS_pc, 32'h104);

        // Load with one FETCH stall and three WB stalls
        do_reset();
        PCS_opcode = OP_LOAD;
        PCS_funct3 = 3'b010;
        @(negedge CLK);
        check_val("ld.fetch_stall", 32'(PCS_fetch_en), 32'd1);
        PCS_mem_ack = 1'b1;
        @(negedge CLK);
        check_val("ld.exec", 32'(PCS_exec), 32'd1);
        PCS_mem_ack = 1'b0;
        @(negedge CLK);
        check_val("ld.pc_after_exec", PCS_pc, 32'h104);
        for (int k = 0; k < 4; k++) begin
            check_val($sformatf("ld.wb%0d", k), 32'(PCS_wb), 32'd1);
            check_val($sformatf("ld.ret%0d", k), PCS_retired, 32'd0);
            if (k == 3) PCS_mem_ack = 1'b1;
            @(negedge CLK);
        end
        PCS_mem_ack = 1'b0;
        check_val("ld.wb_done", 32'(PCS_wb), 32'd0);
        check_val("ld.fetch_en", 32'(PCS_fetch_en), 32'd1);
        check_val("ld.retired", PCS_retired, 32'd1);
        check_val("ld.pc", PCS_pc, 32'h104);

        // Interrupt at retire of an instruction at pc = 0x10
        do_reset();
        PCS_jal_tgt = 32'h0000_0010;
        do_instr(OP_JAL, 3'b000, 3'b000, 1'b0, "jal10");
        PCS_jal_tgt = 32'h0000_0400;
        check_val("jal10.pc", PCS_pc, 32'h10);
        PCS_intr = 1'b1;
        do_instr(OP_IMM, 3'b000, 3'b000, 1'b0, "irq");
        check_val("irq.int_taken", 32'(PCS_int_taken), 32'd1);
        check_val("irq.pc", PCS_pc, 32'h14);
        check_val("irq.fetch_en", 32'(PCS_fetch_en), 32'd0);
        check_val("irq.retired", PCS_retired, 32'd2);
        PCS_intr = 1'b0;
        @(negedge CLK);
        check_val("irq.int_done", 32'(PCS_int_taken), 32'd0);
        check_val("irq.vec_pc", PCS_pc, 32'h1C0);
        check_val("irq.vec_fetch", 32'(PCS_fetch_en), 32'd1);
        check_val("irq.retired2", PCS_retired, 32'd2);

        // Retire counter wrap: counter preset to all-ones while in EXEC
        do_reset();
        PCS_opcode  = OP_IMM;
        PCS_mem_ack = 1'b1;
        @(negedge CLK);
        PCS_mem_ack = 1'b0;
        force dut.retired_q = 32'hFFFF_FFFF;
        #1;
        check_val("wrap.next", dut.retired_d, 32'd0);
        release dut.retired_q;
        @(negedge CLK);

        // Reset asserted in the middle of WB
        do_reset();
        do_instr(OP_IMM, 3'b000, 3'b000, 1'b0, "pre");
        PCS_opcode  = OP_LOAD;
        PCS_mem_ack = 1'b1;
        @(negedge CLK);
        PCS_mem_ack = 1'b0;
        @(negedge CLK);
        check_val("midwb.wb", 32'(PCS_wb), 32'd1);
        check_val("midwb.retired", PCS_retired, 32'd1);
        RST_N = 1'b0;
        #1;
        check_val("midwb.rst_pc", PCS_pc, 32'h100);
        check_val("midwb.rst_wb", 32'(PCS_wb), 32'd0);
        check_val("midwb.rst_retired", PCS_retired, 32'd0);
        check_val("midwb.rst_fetch_en", 32'(PCS_fetch_en), 32'd0);
        @(negedge CLK);
        RST_N = 1'b1;
        #1;
        check_val("midwb.rel_fetch_en", 32'(PCS_fetch_en), 32'd1);
        check_val("midwb.rel_pc_plus4", PCS_pc_plus4, 32'h104);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_pc_sequencer

// File: doc/pc_sequencer.md
# pc_sequencer

Multi-cycle program-counter sequencer for the RISC-V OTTER MCU. It consumes the three comparison flags from the branch condition generator (`eq`, `lt`, `ltu`) together with `funct3` and `opcode`, and resolves the branch decision. It also owns the PC register, the fetch/execute/writeback/interrupt state machine and a retired-instruction counter. It sits between instruction memory, the immediate/target generators and the CSR block.

## Interface
Parameters:
- RESET_VEC, 32'h0000_0000, PC value loaded on reset.

Ports:
- CLK  in  1  system clock; all state changes on rising edge.
- RST_N  in  1  reset, asynchronous assert, active-low.
- PCS_opcode  in  7  opcode of the instruction held in the IR.
- PCS_funct3  in  3  funct3 field of the IR.
- PCS_br_eq / PCS_br_lt / PCS_br_ltu  in  1 each  comparison flags for rs1 vs rs2.
- PCS_jal_tgt / PCS_jalr_tgt / PCS_branch_tgt  in  32 each  precomputed targets.
- PCS_mtvec / PCS_mepc  in  32 each  trap vector and return address from the CSR block.
- PCS_intr  in  1  level interrupt request, already masked by mie.
- PCS_mem_ack  in  1  memory read data valid (instruction in FETCH, load data in WB).
- PCS_pc  out  32  current PC.
- PCS_pc_plus4  out  32  PCS_pc + 4, mod 2^32.
- PCS_fetch_en  out  1  instruction read enable.
- PCS_exec  out  1  high in EXEC; enables register-file and CSR writes.
- PCS_wb  out  1  high in WB; enables load writeback.
- PCS_br_taken  out  1  resolved branch decision, valid in EXEC only.
- PCS_int_taken  out  1  high in INTR; CSR block captures PCS_pc into mepc.
- PCS_retired  out  32  count of retired instructions.

## Operation
- States: FETCH, EXEC, WB, INTR.
- FETCH:
  - PCS_fetch_en = 1.
  - Stay in FETCH until PCS_mem_ack, then go to EXEC.
  - PCS_intr is not sampled in FETCH.
- EXEC:
  - Branch decision by funct3 (only when opcode = 1100011):
    - 000 → eq; 001 → !eq.
    - 100 → lt; 101 → !lt.
    - 110 → ltu; 111 → !ltu.
    - 010 and 011 → not taken.
  - PCS_br_taken = 0 for all non-branch opcodes.
  - Next PC, latched at the end of EXEC:
    - JAL (1101111) → jal_tgt.
    - JALR (1100111) → {jalr_tgt[31:1], 1'b0}.
    - Branch taken → branch_tgt.
    - SYSTEM (1110011) with funct3 = 000 → PCS_mepc (mret).
    - Otherwise → pc + 4.
  - Target bits [1:0] are not checked.
  - Load (0000011) → go to WB; all other opcodes → retire.
  - PCS_mem_ack is ignored in EXEC.
- WB: stay in WB until PCS_mem_ack, then retire. The PC does not change in WB.
- Retire:
  - PCS_retired increments by 1 and wraps at 2^32.
  - If PCS_intr = 1 in the retiring cycle → INTR, else → FETCH.
- INTR:
  - PCS_int_taken = 1; PCS_pc still holds the return address.
  - At the end of the cycle, PC ← PCS_mtvec and state → FETCH.
  - INTR lasts exactly one cycle; it does not count as a retire.
- Reset (RST_N = 0, any state, mid-instruction included):
  - PC = RESET_VEC, state = FETCH, PCS_retired = 0.
  - PCS_exec, PCS_wb, PCS_br_taken, PCS_int_taken = 0.
  - PCS_fetch_en = 0; it is gated by RST_N.
  - PCS_pc_plus4 = RESET_VEC + 4.

## Timing
- Output timing:
  - PCS_fetch_en, PCS_exec, PCS_wb, PCS_int_taken are Moore decodes of state.
  - PCS_br_taken is combinational from inputs during EXEC.
- Latency:
  - Non-load instruction, ack in the first FETCH cycle: 2 cycles.
  - Load: 3 cycles + 1 per cycle without ack in FETCH or WB.
  - Interrupt: +1 cycle.
- The PC update and the retire increment occur on the same edge that leaves EXEC (non-load) or WB (load).
- PCS_intr that rises and falls entirely within FETCH or EXEC of a load is lost; the source must hold it until PCS_int_taken.

## Structure
- Package otter_pkg holds:
  - pcs_state_t enum {FETCH, EXEC, WB, INTR}.
  - Opcode localparams OP_BRANCH, OP_JAL, OP_JALR, OP_LOAD, OP_SYSTEM.
  - funct3 localparams for the six branch types.
- One combinational sub-module, otter_next_pc: inputs are opcode, funct3, flags, targets and mepc; outputs are br_taken and next_pc.
- The top level holds the FSM, PC register and retire counter.

## Test plan
- Reset with RESET_VEC = 32'h100 → PCS_pc = 32'h100, PCS_pc_plus4 = 32'h104, PCS_retired = 0, PCS_fetch_en = 0 while RST_N = 0 and 1 on the first cycle after release.
- All six funct3 codes × both flag values, branch_tgt = 32'h200 from pc = 32'h100 → PC = 32'h200 exactly when taken, else 32'h104; funct3 = 010 → 32'h104.
- JALR with jalr_tgt = 32'h303 → PC = 32'h302; JAL with jal_tgt = 32'h400 → PC = 32'h400; mret with mepc = 32'h88 → PC = 32'h88.
- Load with mem_ack held low 3 cycles in WB → PCS_wb high 4 cycles, PCS_retired increments once, PC = pc + 4 after EXEC.
- PCS_intr held high during retire at pc = 32'h10 → one-cycle PCS_int_taken with PCS_pc = 32'h14, then PC = PCS_mtvec in FETCH.
- RST_N dropped mid-WB, and the retire counter preloaded near 32'hFFFF_FFFF → immediate return to FETCH/RESET_VEC with counter 0; in a separate run without reset, the counter wraps to 0.
